// File: rtl/i2c_reg_master.sv
// ---------------------------------------------------------------------------
// i2c_reg_master
//
// Single-master I2C controller for one-byte register transactions to 7-bit
// addressed slaves. One command produces one frame without repeated start:
//   START, A6..A0, RW, ACK, R7..R0, ACK, D7..D0, ACK/NACK, STOP
// Writes send D7..D0 from the master. Reads sample D7..D0 from the slave and
// finish with a master NACK. A NACK in any ACK slot skips the rest of the
// frame and goes straight to STOP, reporting which phase failed.
//
// Bit timing: each bit is four quarters of CLK_DIV clk cycles.
//   Q0 SCL low  (SDA updated at the start of Q0)
//   Q1 SCL low
//   Q2 SCL high (SDA sampled on the last clk of Q2)
//   Q3 SCL high
// START holds SDA low with SCL high for two quarters. STOP takes three
// quarters: SCL low/SDA low, SCL high/SDA low, SCL high/SDA released.
//
// Parameters
//   CLK_DIV      clk cycles per SCL quarter period, must be >= 2
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   cmd_valid    command request
//   cmd_ready    high in IDLE only; accept on cmd_valid & cmd_ready
//   cmd_rw       0 = write, 1 = read
//   cmd_slv_addr 7-bit slave address
//   cmd_reg_addr 8-bit register address
//   cmd_wdata    write byte (unused for reads)
//   done         one-cycle pulse at transaction end
//   err          valid with done: 00 ok, 01 addr NACK, 10 reg NACK,
//                11 write-data NACK
//   rdata        read byte, updated with done on error-free reads only
//   busy         high from acceptance through the done cycle
//   SCL          bus clock, push-pull, idle high
//   SDA          open-drain data: driven low or released
// ---------------------------------------------------------------------------
module i2c_reg_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_slv_addr,
  input  logic [7:0] cmd_reg_addr,
  input  logic [7:0] cmd_wdata,
  output logic       done,
  output logic [1:0] err,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       SCL,
  inout  wire        SDA
);

  localparam int QW = $clog2(CLK_DIV);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_START      = 4'd1,
    ST_ADDR       = 4'd2,
    ST_ADDR_ACK   = 4'd3,
    ST_REG        = 4'd4,
    ST_REG_ACK    = 4'd5,
    ST_WDATA      = 4'd6,
    ST_WDATA_ACK  = 4'd7,
    ST_RDATA      = 4'd8,
    ST_RDATA_NACK = 4'd9,
    ST_STOP       = 4'd10,
    ST_DONE       = 4'd11
  } state_t;

  state_t         state_reg;
  state_t         state_next;

  logic [QW-1:0]  q_cnt;
  logic [1:0]     phase_cnt;
  logic [2:0]     bit_cnt;

  logic           rw_reg;
  logic [6:0]     slv_addr_reg;
  logic [7:0]     reg_addr_reg;
  logic [7:0]     wdata_reg;

  logic           ack_bit;
  logic [7:0]     rx_shift;
  logic [1:0]     err_reg;
  logic [7:0]     rdata_reg;

  logic           q_last;
  logic           bit_end;
  logic           sample_pt;
  logic           data_state;
  logic           sda_in;
  logic           sda_low;
  logic [7:0]     tx_byte;

  assign q_last    = (q_cnt == QW'(CLK_DIV - 1));
  assign bit_end   = q_last && (phase_cnt == 2'd3);
  assign sample_pt = q_last && (phase_cnt == 2'd2);
  assign data_state = (state_reg == ST_ADDR) || (state_reg == ST_REG) ||
                      (state_reg == ST_WDATA) || (state_reg == ST_RDATA);

  // Open-drain: the master only ever pulls low; the pull-up supplies the 1.
  assign SDA    = sda_low ? 1'b0 : 1'bz;
  assign sda_in = SDA;

  assign err   = err_reg;
  assign rdata = rdata_reg;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:       if (cmd_valid) state_next = ST_START;
      ST_START:      if (q_last && (phase_cnt == 2'd1)) state_next = ST_ADDR;
      ST_ADDR:       if (bit_end && (bit_cnt == 3'd0)) state_next = ST_ADDR_ACK;
      ST_ADDR_ACK:   if (bit_end) state_next = ack_bit ? ST_STOP : ST_REG;
      ST_REG:        if (bit_end && (bit_cnt == 3'd0)) state_next = ST_REG_ACK;
      ST_REG_ACK: begin
        if (bit_end) begin
          if (ack_bit)     state_next = ST_STOP;
          else if (rw_reg) state_next = ST_RDATA;
          else             state_next = ST_WDATA;
        end
      end
      ST_WDATA:      if (bit_end && (bit_cnt == 3'd0)) state_next = ST_WDATA_ACK;
      ST_WDATA_ACK:  if (bit_end) state_next = ST_STOP;
      ST_RDATA:      if (bit_end && (bit_cnt == 3'd0)) state_next = ST_RDATA_NACK;
      ST_RDATA_NACK: if (bit_end) state_next = ST_STOP;
      ST_STOP:       if (q_last && (phase_cnt == 2'd2)) state_next = ST_DONE;
      ST_DONE:       state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (SCL, SDA drive, handshake)
  // -------------------------------------------------------------------------
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    SCL       = 1'b1;
    sda_low   = 1'b0;
    tx_byte   = 8'h00;

    case (state_reg)
      ST_ADDR:  tx_byte = {slv_addr_reg, rw_reg};
      ST_REG:   tx_byte = reg_addr_reg;
      ST_WDATA: tx_byte = wdata_reg;
      default:  tx_byte = 8'h00;
    endcase

    case (state_reg)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_START: begin
        sda_low = 1'b1;
      end
      ST_ADDR, ST_REG, ST_WDATA: begin
        // SCL is high in quarters 2 and 3 of every bit.
        SCL     = phase_cnt[1];
        sda_low = ~tx_byte[bit_cnt];
      end
      ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK, ST_RDATA, ST_RDATA_NACK: begin
        // Slave owns SDA (ACK or read data); the final read bit is a
        // released line, i.e. a master NACK.
        SCL = phase_cnt[1];
      end
      ST_STOP: begin
        SCL     = (phase_cnt != 2'd0);
        sda_low = (phase_cnt != 2'd2);
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: timing counters, command latch, receive shifter, status
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_cnt        <= '0;
      phase_cnt    <= 2'd0;
      bit_cnt      <= 3'd7;
      rw_reg       <= 1'b0;
      slv_addr_reg <= 7'h00;
      reg_addr_reg <= 8'h00;
      wdata_reg    <= 8'h00;
      ack_bit      <= 1'b0;
      rx_shift     <= 8'h00;
      err_reg      <= 2'b00;
      rdata_reg    <= 8'h00;
    end else if (state_reg == ST_IDLE) begin
      q_cnt     <= '0;
      phase_cnt <= 2'd0;
      bit_cnt   <= 3'd7;
      if (cmd_valid) begin
        rw_reg       <= cmd_rw;
        slv_addr_reg <= cmd_slv_addr;
        reg_addr_reg <= cmd_reg_addr;
        wdata_reg    <= cmd_wdata;
        err_reg      <= 2'b00;
      end
    end else begin
      // Every state starts at quarter 0 of phase 0; within a byte the phase
      // counter simply wraps from 3 back to 0 for the next bit.
      if (state_next != state_reg) begin
        q_cnt     <= '0;
        phase_cnt <= 2'd0;
      end else if (q_last) begin
        q_cnt     <= '0;
        phase_cnt <= phase_cnt + 2'd1;
      end else begin
        q_cnt <= q_cnt + QW'(1);
      end

      // Counts 7 down to 0 and wraps back to 7 as the byte completes.
      if (data_state && bit_end) begin
        bit_cnt <= bit_cnt - 3'd1;
      end

      if (sample_pt) begin
        ack_bit <= sda_in;
        if (state_reg == ST_RDATA) begin
          rx_shift <= {rx_shift[6:0], sda_in};
        end
      end

      if (bit_end && ack_bit) begin
        case (state_reg)
          ST_ADDR_ACK:  err_reg <= 2'b01;
          ST_REG_ACK:   err_reg <= 2'b10;
          ST_WDATA_ACK: err_reg <= 2'b11;
          default:      err_reg <= err_reg;
        endcase
      end

      // Loaded on the edge into DONE so the byte is presented alongside done.
      if ((state_reg == ST_STOP) && (state_next == ST_DONE) &&
          (err_reg == 2'b00) && rw_reg) begin
        rdata_reg <= rx_shift;
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_master.sv
// ---------------------------------------------------------------------------
// tb_i2c_reg_master
//
// Directed bench for i2c_reg_master (CLK_DIV = 4). A behavioural register
// slave at 7'h01 with 16 byte registers sits on the bus; it also counts
// START/STOP conditions, SCL rising edges and master NACKs after read data.
// ---------------------------------------------------------------------------
module tb_i2c_reg_master;

  localparam int         CLK_DIV = 4;
  localparam logic [6:0] SLV     = 7'h01;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_slv_addr = 7'h00;
  logic [7:0] cmd_reg_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       done;
  logic [1:0] err;
  logic [7:0] rdata;
  logic       busy;
  logic       scl;
  wire        sda;

  int checks = 0;
  int errors = 0;

  // Bus slave / monitor state
  logic       s_low = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       s_active = 1'b0;
  logic       s_ack = 1'b0;
  logic       s_rw = 1'b0;
  logic [7:0] s_shift = 8'h00;
  logic [3:0] s_ptr = 4'h0;
  int         s_bitn = 0;
  int         s_byten = 0;
  int         start_cnt = 0;
  int         stop_cnt = 0;
  int         rise_cnt = 0;
  int         nack_cnt = 0;
  logic [7:0] slv_regs [16] = '{default: 8'h00};

  pullup (sda);
  assign sda = s_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_reg_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_rw       (cmd_rw),
    .cmd_slv_addr (cmd_slv_addr),
    .cmd_reg_addr (cmd_reg_addr),
    .cmd_wdata    (cmd_wdata),
    .done         (done),
    .err          (err),
    .rdata        (rdata),
    .busy         (busy),
    .SCL          (scl),
    .SDA          (sda)
  );

  // Slave model and protocol monitor, sampled mid-cycle. Any SDA change seen
  // while SCL stays high is a START or STOP; illegal data changes therefore
  // show up as extra START/STOP counts.
  always @(negedge clk) begin : mon
    logic [7:0] byte_v;
    prev_scl <= scl;
    prev_sda <= sda;
    if (prev_scl && scl && prev_sda && !sda) begin
      start_cnt <= start_cnt + 1;
      s_active  <= 1'b1;
      s_bitn    <= 0;
      s_byten   <= 0;
      s_low     <= 1'b0;
    end else if (prev_scl && scl && !prev_sda && sda) begin
      stop_cnt <= stop_cnt + 1;
      s_active <= 1'b0;
      s_low    <= 1'b0;
    end else if (!prev_scl && scl) begin
      rise_cnt <= rise_cnt + 1;
      if (s_active) begin
        if (s_bitn < 8) begin
          byte_v  = {s_shift[6:0], sda};
          s_shift <= byte_v;
          s_bitn  <= s_bitn + 1;
          if (s_bitn == 7) begin
            case (s_byten)
              0: begin
                s_ack <= (byte_v[7:1] == SLV);
                s_rw  <= byte_v[0];
              end
              1: begin
                s_ack <= (byte_v < 8'd16);
                s_ptr <= byte_v[3:0];
              end
              default: begin
                if (!s_rw) begin
                  slv_regs[s_ptr] <= byte_v;
                  s_ack <= 1'b1;
                end
              end
            endcase
          end
        end else begin
          if ((s_byten == 2) && s_rw && sda) nack_cnt <= nack_cnt + 1;
          s_bitn  <= 0;
          s_byten <= s_byten + 1;
          if (!s_ack) s_active <= 1'b0;
        end
      end
    end else if (prev_scl && !scl) begin
      if (!s_active)
        s_low <= 1'b0;
      else if (s_bitn == 8)
        s_low <= s_ack && !((s_byten == 2) && s_rw);
      else if ((s_byten == 2) && s_rw)
        s_low <= !slv_regs[s_ptr][7 - s_bitn];
      else
        s_low <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command; checks latency, status, bus activity and handshake.
  task automatic run_cmd(input string name, input logic rw, input logic [6:0] slv,
                         input logic [7:0] ra, input logic [7:0] wd,
                         input int exp_lat, input logic [1:0] exp_err,
                         input int exp_rises, input int exp_nacks,
                         output logic [7:0] rd);
    int lat;
    int r0, s0, p0, n0;
    bit ready_leak;
    ready_leak = 1'b0;
    @(negedge clk);
    chk({name, "_ready_before"}, cmd_ready, 1);
    r0 = rise_cnt; s0 = start_cnt; p0 = stop_cnt; n0 = nack_cnt;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_slv_addr = slv; cmd_reg_addr = ra; cmd_wdata = wd;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    chk({name, "_busy"}, busy, 1);
    // Fields latched at acceptance; cmd_valid stays high to probe re-acceptance.
    cmd_rw = ~rw; cmd_slv_addr = ~slv; cmd_reg_addr = ~ra; cmd_wdata = ~wd;
    while (!done && lat < 2000) begin
      if (cmd_ready) ready_leak = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({name, "_done_seen"}, done, 1);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_err"}, err, exp_err);
    chk({name, "_ready_leak"}, ready_leak, 0);
    rd = rdata;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({name, "_done_pulse"}, done, 0);
    chk({name, "_ready_after"}, cmd_ready, 1);
    chk({name, "_idle_bus"}, {busy, scl, sda}, 3'b011);
    chk({name, "_starts"}, start_cnt - s0, 1);
    chk({name, "_stops"}, stop_cnt - p0, 1);
    chk({name, "_scl_rises"}, rise_cnt - r0, exp_rises);
    chk({name, "_master_nack"}, nack_cnt - n0, exp_nacks);
    $display("txn %s: rw=%0d slv=%02h reg=%02h wd=%02h lat=%0d err=%0d rdata=%02h",
             name, rw, slv, ra, wd, lat, err, rd);
  endtask

  initial begin
    logic [7:0] rd;
    int p0;

    // Reset state
    #1;
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_cmd("wr_03", 1'b0, SLV, 8'h03, 8'hA5, 452, 2'b00, 28, 0, rd);
    chk("wr_03_slvreg", slv_regs[3], 8'hA5);

    run_cmd("rd_03", 1'b1, SLV, 8'h03, 8'h00, 452, 2'b00, 28, 1, rd);
    chk("rd_03_rdata", rd, 8'hA5);

    run_cmd("wr_0f", 1'b0, SLV, 8'h0F, 8'h3C, 452, 2'b00, 28, 0, rd);
    chk("wr_0f_slvreg", slv_regs[15], 8'h3C);
    chk("wr_0f_rdata_hold", rd, 8'hA5);

    run_cmd("rd_0f", 1'b1, SLV, 8'h0F, 8'h00, 452, 2'b00, 28, 1, rd);
    chk("rd_0f_rdata", rd, 8'h3C);

    run_cmd("addr_nack", 1'b0, 7'h05, 8'h03, 8'h11, 164, 2'b01, 10, 0, rd);
    chk("addr_nack_slvreg", slv_regs[3], 8'hA5);

    run_cmd("reg_nack", 1'b1, SLV, 8'h20, 8'h00, 308, 2'b10, 19, 0, rd);
    chk("reg_nack_rdata", rd, 8'h3C);

    // Reset mid-frame while SCL and SDA are both low (A6 of 7'h01 is 0).
    @(negedge clk);
    p0 = stop_cnt;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_slv_addr = SLV; cmd_reg_addr = 8'h05; cmd_wdata = 8'h77;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_scl_low", scl, 0);
    chk("mid_sda_low", sda, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_scl", scl, 1);
    chk("mid_rst_sda", sda, 1);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_rdata", rdata, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_stop", stop_cnt - p0, 0);
    $display("txn mid_reset: bus released, no STOP");

    run_cmd("rd_03_again", 1'b1, SLV, 8'h03, 8'h00, 452, 2'b00, 28, 1, rd);
    chk("rd_03_again_rdata", rd, 8'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
